dff_shift_reg: RTL and testbench
================================

DFF_SHIFT_REG -- requirements
Module: dff_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning register width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter CNT_W, default $clog2(WIDTH), meaning the frame counter width; it SHALL NOT be overridden.
REQ-003 The block SHALL have port clk, input, width 1, meaning the single clock; all state updates SHALL occur on its rising edge.
REQ-004 The block SHALL have port rst, input, width 1, meaning the reset; it SHALL be synchronous and active-high.
REQ-005 The block SHALL have port en, input, width 1, meaning the operation enable.
REQ-006 The block SHALL have port mode, input, width 2, meaning operation select: 00 HOLD, 01 LOAD, 10 SHL, 11 SHR.
REQ-007 The block SHALL have port d, input, width WIDTH, meaning the parallel load data.
REQ-008 The block SHALL have port sin, input, width 1, meaning the serial input bit.
REQ-009 The block SHALL have port rot, input, width 1, meaning the rotate request; it SHALL be functional only under ROTATE_EN.
REQ-010 The block SHALL have port q, output, width WIDTH, meaning the register contents.
REQ-011 The block SHALL have port sout, output, width 1, meaning the last bit shifted out, registered.
REQ-012 The block SHALL have port done, output, width 1, meaning a one-cycle pulse marking a completed WIDTH-bit serial frame.

Function
REQ-013 When en=0, q, sout and the frame counter SHALL hold; done SHALL be 0 on the next cycle.
REQ-014 In HOLD with en=1, all state SHALL hold and done SHALL be 0 on the next cycle.
REQ-015 In LOAD with en=1, the block SHALL set q<=d and clear the frame counter to 0; sout SHALL hold and done SHALL be 0.
REQ-016 In SHL with en=1, the block SHALL set q<={q[WIDTH-2:0],in} and sout<=q[WIDTH-1].
REQ-017 In SHR with en=1, the block SHALL set q<={in,q[WIDTH-1:1]} and sout<=q[0].
REQ-018 For REQ-016 and REQ-017, in SHALL equal sin unless it is overridden by REQ-025.
REQ-019 Latency SHALL be one cycle: q and sout SHALL reflect an operation on the clock edge that samples it.
REQ-020 Each SHL or SHR with en=1 SHALL increment the frame counter by 1.
REQ-021 The frame counter SHALL wrap from WIDTH-1 to 0; on that wrap, done SHALL be 1 for exactly the following cycle.
REQ-022 The frame counter SHALL be shared by SHL and SHR; switching shift direction mid-frame SHALL NOT clear it.
REQ-023 A LOAD issued mid-frame SHALL abort the frame: the counter SHALL clear and done SHALL NOT pulse.

Reset
REQ-024 When rst=1 at a rising edge, the block SHALL set q=0, sout=0, done=0 and the counter to 0, with priority over en and mode; operation SHALL resume on the first edge with rst=0, and a frame in progress SHALL be discarded without a done pulse.

Configuration
REQ-025 With macro DFF_SHIFT_ROTATE_EN defined, SHL/SHR with rot=1 SHALL feed back the outgoing bit (in=q[WIDTH-1] for SHL, q[0] for SHR) instead of sin; the counter and done SHALL behave as for a normal shift.
REQ-026 Without DFF_SHIFT_ROTATE_EN, rot SHALL be ignored (tied into an unused-signal sink), and in SHALL always be sin.

Structure
REQ-027 Package dff_shift_pkg SHALL hold the mode typedef (enum MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR) and the mode encodings; the module SHALL use only those names.
REQ-028 The frame counter with its wrap/done logic SHALL be a sub-module dff_shift_frame_cnt (inputs: clk, rst, clr, inc; output: done); the shifter datapath SHALL stay in dff_shift_reg.

Verification (WIDTH=8)
REQ-029 Reset: bench SHALL drive rst=1 for 2 cycles with mode=LOAD, d=8'hFF, then check q=8'h00, sout=0, done=0.
REQ-030 Load/hold: bench SHALL apply LOAD d=8'hA5, then HOLD for 3 cycles, then en=0 with LOAD d=8'h00, and check q=8'hA5 throughout.
REQ-031 Shift frame: bench SHALL load 8'h81 then apply 8 SHL with sin=0, and check q=8'h00, the sout sequence 1,0,0,0,0,0,0,1, and done=1 only in the cycle after the 8th shift.
REQ-032 Abort: bench SHALL apply 5 SHR, LOAD 8'h3C, then 8 SHR, and check that done pulses once, after the 8th post-load shift, not earlier.
REQ-033 Reset mid-frame: bench SHALL apply 6 SHL, rst for 1 cycle, then 8 SHL, and check q=0 after reset and done only after the 8th post-reset shift.
REQ-034 Rotate (macro defined): bench SHALL load 8'h01 and apply 8 SHL with rot=1, sin=0, and check q=8'h01 and done=1; with the macro undefined, the same stimulus SHALL give q=8'h00.

Source files
------------

// File: rtl/dff_shift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dff_shift_pkg
// Description : Mode encodings shared by the shift register and its bench.
// Revision    : 1.0 - initial release
// ============================================================================

package dff_shift_pkg;

    localparam int c_MODE_W = 2;

    typedef enum logic [c_MODE_W-1:0] {
        MODE_HOLD = 2'b00,
        MODE_LOAD = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_SHR  = 2'b11
    } mode_e;

endpackage : dff_shift_pkg

`default_nettype wire

// File: rtl/dff_shift_frame_cnt.sv
`default_nettype none
// ============================================================================
// Module      : dff_shift_frame_cnt
// Description : Serial frame counter; pulses done for one cycle on wrap.
// Revision    : 1.0 - initial release
// ============================================================================

module dff_shift_frame_cnt #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic done
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_done;

    // A clear always wins over an increment, so an aborted frame never pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (clr) begin
                r_cnt <= '0;
            end else if (inc) begin
                if (r_cnt == c_LAST) begin
                    r_cnt  <= '0;
                    r_done <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign done = r_done;

endmodule : dff_shift_frame_cnt

`default_nettype wire

// File: rtl/dff_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : dff_shift_reg
// Description : Loadable bidirectional shift register with frame-done pulse.
//               Optional rotate feedback enabled by macro DFF_SHIFT_ROTATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================

module dff_shift_reg
    import dff_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    input  logic             rot,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             done
);

    logic [WIDTH-1:0] r_q;
    logic             r_sout;

    mode_e            w_mode;
    logic             w_shl_in;
    logic             w_shr_in;
    logic             w_load;
    logic             w_shift;
    logic [WIDTH-1:0] w_q_next;
    logic             w_sout_next;

    assign w_mode = mode_e'(mode);

`ifdef DFF_SHIFT_ROTATE_EN
    assign w_shl_in = rot ? r_q[WIDTH-1] : sin;
    assign w_shr_in = rot ? r_q[0]       : sin;
`else
    logic w_unused;
    assign w_unused = rot;
    assign w_shl_in = sin;
    assign w_shr_in = sin;
`endif

    always_comb begin
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_q_next    = r_q;
        w_sout_next = r_sout;
        if (en) begin
            case (w_mode)
                MODE_LOAD: begin
                    w_load   = 1'b1;
                    w_q_next = d;
                end
                MODE_SHL: begin
                    w_shift     = 1'b1;
                    w_q_next    = {r_q[WIDTH-2:0], w_shl_in};
                    w_sout_next = r_q[WIDTH-1];
                end
                MODE_SHR: begin
                    w_shift     = 1'b1;
                    w_q_next    = {w_shr_in, r_q[WIDTH-1:1]};
                    w_sout_next = r_q[0];
                end
                default: begin
                    w_q_next    = r_q;
                    w_sout_next = r_sout;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            r_sout <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_sout <= w_sout_next;
        end
    end

    dff_shift_frame_cnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_frame_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_load),
        .inc  (w_shift),
        .done (done)
    );

    assign q    = r_q;
    assign sout = r_sout;

endmodule : dff_shift_reg

`default_nettype wire

// File: tb/tb_dff_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_dff_shift_reg
// Description : Self-checking bench for dff_shift_reg (WIDTH=8) with a
//               behavioural model, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_dff_shift_reg;
    import dff_shift_pkg::*;

`ifdef DFF_SHIFT_ROTATE_EN
    localparam bit c_ROT_EN = 1'b1;
`else
    localparam bit c_ROT_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] d;
    logic       sin;
    logic       rot;
    logic [7:0] q;
    logic       sout;
    logic       done;

    int checks   = 0;
    int failures = 0;

    dff_shift_reg #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .d    (d),
        .sin  (sin),
        .rot  (rot),
        .q    (q),
        .sout (sout),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: register value, last bit out, shifts so far in frame.
    logic [7:0] m_q     = 8'h00;
    logic       m_sout  = 1'b0;
    logic       m_done  = 1'b0;
    int         m_cnt   = 0;
    bit         m_valid = 1'b0;

    always @(posedge clk) begin
        logic [7:0] nq;
        logic       ns;
        logic       nd;
        logic       bin;
        int         nc;
        nq = m_q; ns = m_sout; nd = 1'b0; nc = m_cnt;
        if (rst) begin
            nq = 8'h00; ns = 1'b0; nc = 0;
            m_valid <= 1'b1;
        end else if (en) begin
            if (mode == MODE_LOAD) begin
                nq = d; nc = 0;
            end else if (mode == MODE_SHL || mode == MODE_SHR) begin
                if (mode == MODE_SHL) begin
                    bin = (c_ROT_EN && rot) ? m_q[7] : sin;
                    ns  = m_q[7];
                    nq  = (m_q << 1) | {7'b0, bin};
                end else begin
                    bin = (c_ROT_EN && rot) ? m_q[0] : sin;
                    ns  = m_q[0];
                    nq  = (m_q >> 1) | (bin ? 8'h80 : 8'h00);
                end
                nc = nc + 1;
                if (nc == 8) begin
                    nc = 0;
                    nd = 1'b1;
                end
            end
        end
        m_q    <= nq;
        m_sout <= ns;
        m_done <= nd;
        m_cnt  <= nc;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_q",    32'(q),    32'(m_q));
            check("model_sout", 32'(sout), 32'(m_sout));
            check("model_done", 32'(done), 32'(m_done));
        end
    end

    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic [7:0] dv, input logic s, input logic ro);
        @(negedge clk);
        rst = r; en = e; mode = m; d = dv; sin = s; rot = ro;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_sout;
        rst = 1'b0; en = 1'b0; mode = MODE_HOLD; d = 8'h00; sin = 1'b0; rot = 1'b0;

        // Reset with conflicting load request
        step(1, 1, MODE_LOAD, 8'hFF, 1, 0);
        step(1, 1, MODE_LOAD, 8'hFF, 1, 0);
        check("reset_q",    32'(q),    32'h00);
        check("reset_sout", 32'(sout), 32'h0);
        check("reset_done", 32'(done), 32'h0);

        // Load and hold
        step(0, 1, MODE_LOAD, 8'hA5, 0, 0);
        check("load_q", 32'(q), 32'hA5);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, MODE_HOLD, 8'h5A, 1, 0);
            check("hold_q", 32'(q), 32'hA5);
        end
        step(0, 0, MODE_LOAD, 8'h00, 0, 0);
        check("en0_q", 32'(q), 32'hA5);

        // Full SHL frame
        step(0, 1, MODE_LOAD, 8'h81, 0, 0);
        exp_sout = 8'b1000_0001;
        for (int i = 0; i < 8; i++) begin
            step(0, 1, MODE_SHL, 8'h00, 0, 0);
            check("frame_sout", 32'(sout), 32'(exp_sout[i]));
            check("frame_done", 32'(done), (i == 7) ? 32'h1 : 32'h0);
        end
        check("frame_q", 32'(q), 32'h00);
        step(0, 1, MODE_HOLD, 8'h00, 0, 0);
        check("frame_done_clear", 32'(done), 32'h0);

        // Abort mid-frame with LOAD
        for (int i = 0; i < 5; i++) begin
            step(0, 1, MODE_SHR, 8'h00, 1'($urandom_range(0, 1)), 0);
            check("abort_pre_done", 32'(done), 32'h0);
        end
        step(0, 1, MODE_LOAD, 8'h3C, 0, 0);
        check("abort_load_q", 32'(q), 32'h3C);
        check("abort_load_done", 32'(done), 32'h0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, MODE_SHR, 8'h00, 1'($urandom_range(0, 1)), 0);
            check("abort_done", 32'(done), (i == 7) ? 32'h1 : 32'h0);
        end

        // Reset mid-frame
        for (int i = 0; i < 6; i++) step(0, 1, MODE_SHL, 8'h00, 1, 0);
        step(1, 1, MODE_SHL, 8'h00, 1, 0);
        check("midrst_q",    32'(q),    32'h00);
        check("midrst_done", 32'(done), 32'h0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, MODE_SHL, 8'h00, 1'($urandom_range(0, 1)), 0);
            check("midrst_post_done", 32'(done), (i == 7) ? 32'h1 : 32'h0);
        end

        // Rotate request
        step(0, 1, MODE_LOAD, 8'h01, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, MODE_SHL, 8'h00, 0, 1);
        check("rot_q",    32'(q),    c_ROT_EN ? 32'h01 : 32'h00);
        check("rot_done", 32'(done), 32'h1);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 7) != 0),
                 2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end
        step(0, 0, MODE_HOLD, 8'h00, 0, 0);
        step(0, 0, MODE_HOLD, 8'h00, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dff_shift_reg

`default_nettype wire
